// File: rtl/cache_fill_fsm.sv
// Miss-fill controller for i_cache: fetches one block from pipelined memory, streams it into
// the data array, and writes the tag with the last word. Build option: CRITICAL_WORD_FIRST_EN.
module cache_fill_fsm #(
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic [15:0]       memory_data,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              memory_read,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [ADDR_W-1:0] fill_address,
  output logic [15:0]       fill_data
);

  localparam int OFF_W   = $clog2(BLOCK_WORDS);
  localparam int CNT_W   = OFF_W + 1;
  localparam int BASE_LSB = OFF_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01
  } state_t;

  state_t                    state, state_next;
  logic [ADDR_W-1:BASE_LSB]  base_q;
  logic [OFF_W-1:0]          start_q, start_d;
  logic [CNT_W-1:0]          req_cnt, rcv_cnt;
  logic [OFF_W-1:0]          req_off, rcv_off;
  logic                      req_active, rcv_fire, last_word;

`ifdef CRITICAL_WORD_FIRST_EN
  logic offset_unused;
  assign start_d       = miss_address[OFF_W:1];
  assign offset_unused = miss_address[0];
`else
  logic offset_unused;
  assign start_d       = '0;
  assign offset_unused = ^miss_address[OFF_W:0];
`endif

  // Offsets wrap inside the block; the sum is truncated so no carry reaches base_q.
  assign req_off    = start_q + req_cnt[OFF_W-1:0];
  assign rcv_off    = start_q + rcv_cnt[OFF_W-1:0];
  assign req_active = (state == FILL) && (req_cnt != CNT_FULL);
  assign rcv_fire   = (state == FILL) && memory_data_valid;
  assign last_word  = (rcv_cnt == CNT_LAST);
  assign fill_data  = memory_data;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      base_q  <= '0;
      start_q <= '0;
      req_cnt <= '0;
      rcv_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        if (miss_detected) begin
          base_q  <= miss_address[ADDR_W-1:BASE_LSB];
          start_q <= start_d;
          req_cnt <= '0;
          rcv_cnt <= '0;
        end
      end else begin
        if (req_active) req_cnt <= req_cnt + CNT_W'(1);
        if (rcv_fire && (rcv_cnt != CNT_FULL)) rcv_cnt <= rcv_cnt + CNT_W'(1);
      end
    end
  end

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    state_next       = state;
    fsm_busy         = 1'b0;
    memory_read      = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    fill_address     = '0;
    unique case (state)
      IDLE: begin
        if (miss_detected) state_next = FILL;
      end
      FILL: begin
        fsm_busy = 1'b1;
        if (req_active) begin
          memory_read    = 1'b1;
          memory_address = {base_q, req_off, 1'b0};
        end
        if (rcv_fire) begin
          write_data_array = 1'b1;
          fill_address     = {base_q, rcv_off, 1'b0};
          if (last_word) begin
            write_tag_array = 1'b1;
            state_next      = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: a latency/gap memory model answers requests, expected
// request and fill sequences are derived from the miss address and checked by a monitor.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic [15:0] memory_data = '0;
  logic        memory_data_valid = 1'b0;
  logic        fsm_busy, memory_read, write_data_array, write_tag_array;
  logic [15:0] memory_address, fill_address, fill_data;

  cache_fill_fsm #(.BLOCK_WORDS(8), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data(memory_data), .memory_data_valid(memory_data_valid),
    .fsm_busy(fsm_busy), .memory_read(memory_read), .memory_address(memory_address),
    .write_data_array(write_data_array), .write_tag_array(write_tag_array),
    .fill_address(fill_address), .fill_data(fill_data)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] addr; logic [15:0] data; logic tag; } fill_t;
  typedef struct { int due; logic [15:0] data; } ret_t;

  logic [15:0] req_exp[$];
  fill_t       fill_exp[$];
  ret_t        mem_q[$];
  int          req_log[$], wr_log[$], tag_log[$];
  logic [15:0] req_addr_log[$];
  int          cyc = 0;
  int          lat = 4;
  bit          gaps = 1'b0;
  bit          mon_en = 1'b0;
  bit          model_idle = 1'b1;
  int          busy_cnt = 0;
  int          fill_start_cyc = 0;
  logic [15:0] mem_key = 16'h0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Memory contents: a fixed scramble of the address, keyed per run.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return ({a[6:0], a[15:7]} ^ mem_key) + 16'h1357;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: returns in request order, no earlier than lat cycles, optionally with gaps.
  always @(posedge clk) begin : mem_drv
    ret_t r;
    #1;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc && !(gaps && $urandom_range(2) == 0)) begin
      r = mem_q.pop_front();
      memory_data_valid = 1'b1;
      memory_data       = r.data;
    end else begin
      memory_data_valid = 1'b0;
      memory_data       = 16'($urandom);
    end
  end

  // Monitor: compares DUT activity against the expected queues.
  always @(negedge clk) begin : monitor
    fill_t e;
    model_idle = (fill_exp.size() == 0);
    if (mon_en) begin
      check("busy", {31'd0, fsm_busy}, {31'd0, !model_idle});
      if (model_idle) begin
        check("idle_ctrl", {29'd0, memory_read, write_data_array, write_tag_array}, 32'd0);
        check("idle_addr", {memory_address, fill_address}, 32'd0);
      end
      if (fsm_busy) busy_cnt++;
      if (memory_read === 1'b1) begin
        req_log.push_back(cyc);
        req_addr_log.push_back(memory_address);
        mem_q.push_back('{due: cyc + lat, data: mem_word(memory_address)});
        if (req_exp.size() == 0) check("req_unexpected", {16'd0, memory_address}, 32'hFFFF_FFFF);
        else check("req_addr", {16'd0, memory_address}, {16'd0, req_exp.pop_front()});
      end
      if (write_data_array === 1'b1) begin
        wr_log.push_back(cyc);
        if (fill_exp.size() == 0) begin
          check("wr_unexpected", {16'd0, fill_address}, 32'hFFFF_FFFF);
        end else begin
          e = fill_exp.pop_front();
          check("fill_addr", {16'd0, fill_address}, {16'd0, e.addr});
          check("fill_data", {16'd0, fill_data}, {16'd0, e.data});
          check("tag_write", {31'd0, write_tag_array}, {31'd0, e.tag});
          if (write_tag_array) tag_log.push_back(cyc);
        end
      end else begin
        check("tag_without_data", {31'd0, write_tag_array}, 32'd0);
      end
    end
  end

  task automatic push_expect(input logic [15:0] a);
    logic [15:0] base, addr;
    int st;
`ifdef CRITICAL_WORD_FIRST_EN
    st = int'(a[3:1]);
`else
    st = 0;
`endif
    base = a & 16'hFFF0;
    for (int i = 0; i < 8; i++) begin
      addr = base + 16'(2 * ((st + i) % 8));
      req_exp.push_back(addr);
      fill_exp.push_back('{addr: addr, data: mem_word(addr), tag: (i == 7)});
    end
  endtask

  // Raises a miss and pushes its expectations at the edge where an idle controller takes it.
  task automatic issue_miss(input logic [15:0] a, input bit hold);
    int  waited = 0;
    bit  accepted = 1'b0;
    miss_detected = 1'b1;
    miss_address  = a;
    while (!accepted && waited < 300) begin
      @(posedge clk);
      if (model_idle && !rst) accepted = 1'b1;
      waited++;
    end
    if (!accepted) begin
      check("miss_accept_timeout", 32'd0, 32'd1);
      miss_detected = 1'b0;
      return;
    end
    push_expect(a);
    #1;
    fill_start_cyc = cyc;
    if (!hold) miss_detected = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      #1;
      if (model_idle && fill_exp.size() == 0 && mem_q.size() == 0) done = 1'b1;
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_logs();
    req_log.delete();
    wr_log.delete();
    tag_log.delete();
    req_addr_log.delete();
    busy_cnt = 0;
  endtask

  initial begin
    logic [15:0] a;
    int          first_start;
    mem_key = 16'($urandom);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_ctrl", {28'd0, fsm_busy, memory_read, write_data_array, write_tag_array}, 32'd0);
    check("reset_addr", {memory_address, fill_address}, 32'd0);
    mon_en = 1'b1;
    rst    = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic fill with a fixed 4-cycle memory: exact cycle placement.
    lat = 4; gaps = 1'b0;
    clear_logs();
    issue_miss(16'h1230, 1'b0);
    wait_idle();
    check("req_count", req_log.size(), 32'd8);
    check("wr_count", wr_log.size(), 32'd8);
    check("tag_count", tag_log.size(), 32'd1);
    if (req_log.size() == 8 && wr_log.size() == 8 && tag_log.size() == 1) begin
      check("first_req_cycle", req_log[0] - fill_start_cyc + 1, 32'd1);
      check("last_req_cycle", req_log[7] - fill_start_cyc + 1, 32'd8);
      check("first_wr_cycle", wr_log[0] - fill_start_cyc + 1, 32'd5);
      check("last_wr_cycle", wr_log[7] - fill_start_cyc + 1, 32'd12);
      check("tag_cycle", tag_log[0] - fill_start_cyc + 1, 32'd12);
    end
    check("busy_cycles", busy_cnt, 32'd12);

    // Request order around a mid-block miss.
    clear_logs();
    issue_miss(16'h4A36, 1'b0);
    wait_idle();
    check("cwf_count", req_addr_log.size(), 32'd8);
    if (req_addr_log.size() == 8) begin
`ifdef CRITICAL_WORD_FIRST_EN
      check("cwf_first", {16'd0, req_addr_log[0]}, 32'h4A36);
      check("cwf_wrap", {16'd0, req_addr_log[5]}, 32'h4A30);
`else
      check("cwf_first", {16'd0, req_addr_log[0]}, 32'h4A30);
      check("cwf_wrap", {16'd0, req_addr_log[5]}, 32'h4A3A);
`endif
    end

    // Gapped returns: exactly eight writes, tag with the eighth.
    lat = 3; gaps = 1'b1;
    clear_logs();
    issue_miss(16'($urandom), 1'b0);
    wait_idle();
    check("gap_wr_count", wr_log.size(), 32'd8);
    check("gap_tag_count", tag_log.size(), 32'd1);
    if (wr_log.size() == 8 && tag_log.size() == 1) check("gap_tag_with_last", tag_log[0], wr_log[7]);

    // Reset in cycle 7 of a fill; remaining returns arrive as strays.
    lat = 4; gaps = 1'b0;
    issue_miss(16'($urandom), 1'b0);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_exp.delete();
    fill_exp.delete();
    clear_logs();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_reset_ctrl", {28'd0, fsm_busy, memory_read, write_data_array, write_tag_array}, 32'd0);
    end
    wait_idle();
    check("post_reset_writes", wr_log.size(), 32'd0);

    // Miss held through a fill, address switched to 0x8000 as busy falls.
    lat = 4; gaps = 1'b0;
    clear_logs();
    issue_miss(16'h2468, 1'b1);
    first_start = fill_start_cyc;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (model_idle) break;
    end
    miss_address = 16'h8000;
    issue_miss(16'h8000, 1'b0);
    check("back_to_back_gap", fill_start_cyc - first_start, 32'd13);
    wait_idle();
    check("b2b_req_count", req_addr_log.size(), 32'd16);
    if (req_addr_log.size() == 16) check("b2b_second_first", {16'd0, req_addr_log[8]}, 32'h8000);

    // Top of the address space: no wrap to 0x0000.
    clear_logs();
    issue_miss(16'hFFF0, 1'b0);
    wait_idle();
    if (req_addr_log.size() == 8) check("top_last_req", {16'd0, req_addr_log[7]}, 32'hFFFE);
    else check("top_req_count", req_addr_log.size(), 32'd8);

    // Random misses, latencies and gaps; some issued while a fill is still running.
    for (int k = 0; k < 20; k++) begin
      lat  = int'($urandom_range(6, 1));
      gaps = 1'($urandom_range(1));
      a    = 16'($urandom);
      issue_miss(a, 1'b0);
      if ($urandom_range(1) == 1) wait_idle();
      else repeat ($urandom_range(4)) @(posedge clk);
    end
    wait_idle();
    check("final_req_queue", req_exp.size(), 32'd0);
    check("final_fill_queue", fill_exp.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
